// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the sequential magnitude-to-float converter.
package fpcvt_pkg;

    // Default datapath sizing
    localparam int unsigned IN_W_DEF  = 12;
    localparam int unsigned EXP_W_DEF = 3;
    localparam int unsigned SIG_W_DEF = 4;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest representable exponent for a given exponent width
    function automatic int unsigned emax(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Round-half-up of the normalised significand, with carry into the exponent
// and saturation when the carry would overflow the exponent.
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic [SIG_W-1:0] low_bits,
    input  logic             rbit,
    input  logic [EXP_W-1:0] exp_cur,
    output logic [EXP_W-1:0] exp_c,
    output logic [SIG_W-1:0] sig_c
);

    localparam int unsigned      SUM_W  = SIG_W + 1;
    localparam logic [EXP_W-1:0] EMAX_V = EXP_W'(emax(EXP_W));

    logic [SUM_W-1:0] sum;

    // Add the rounding bit; a carry out renormalises or saturates
    always_comb begin
        sum   = {1'b0, low_bits} + SUM_W'(rbit);
        exp_c = exp_cur;
        sig_c = sum[SIG_W-1:0];
        if (sum[SIG_W]) begin
            if (exp_cur != EMAX_V) begin
                exp_c = exp_cur + EXP_W'(1);
                sig_c = {1'b1, {(SIG_W-1){1'b0}}};
            end else begin
                exp_c = EMAX_V;
                sig_c = '1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to sign/exponent/significand converter.
// Normalises one right-shift per clock, then rounds and presents the result
// over a valid/ready handshake.
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig
);

    localparam int unsigned      MAG_W    = IN_W - 1;
    localparam logic [EXP_W-1:0] EMAX_V   = EXP_W'(emax(EXP_W));
    localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {MAG_W{1'b0}}};

    state_t           state;
    logic [MAG_W-1:0] shreg;
    logic [EXP_W-1:0] exp_q;
    logic             rbit_q;
    logic             sign_q;

    logic [MAG_W-1:0] neg_c;
    logic [MAG_W-1:0] mag_c;
    logic             hi_nz_c;
    logic [EXP_W-1:0] rnd_exp_c;
    logic [SIG_W-1:0] rnd_sig_c;

    // Magnitude of the incoming word; the most-negative value saturates
    always_comb begin
        neg_c = ~in_data[MAG_W-1:0] + MAG_W'(1);
        mag_c = in_data[MAG_W-1:0];
        if (in_data[IN_W-1]) begin
            if (in_data == MOST_NEG) begin
                mag_c = '1;
            end else begin
                mag_c = neg_c;
            end
        end
    end

    assign hi_nz_c = |shreg[MAG_W-1:SIG_W];

    fpcvt_round #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_round (
        .low_bits (shreg[SIG_W-1:0]),
        .rbit     (rbit_q),
        .exp_cur  (exp_q),
        .exp_c    (rnd_exp_c),
        .sig_c    (rnd_sig_c)
    );

    // Control FSM, shift register and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            exp_q     <= '0;
            rbit_q    <= 1'b0;
            sign_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_sig   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_data[IN_W-1];
                        shreg    <= mag_c;
                        exp_q    <= '0;
                        rbit_q   <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (hi_nz_c && (exp_q != EMAX_V)) begin
                        rbit_q <= shreg[0];
                        shreg  <= shreg >> 1;
                        exp_q  <= exp_q + EXP_W'(1);
                    end else begin
                        // Either exponent exhausted (saturate) or ready to round
                        out_sign  <= sign_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (hi_nz_c) begin
                            out_exp <= EMAX_V;
                            out_sig <= '1;
                        end else begin
                            out_exp <= rnd_exp_c;
                            out_sig <= rnd_sig_c;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq at default parameters.
module tb_fpcvt_seq;

    localparam int EMAX = 7;
    localparam int SIGL = 16;   // 2^SIG_W
    localparam int MAXM = 2047; // 2^MAG_W - 1
    localparam int TMO  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [2:0]  out_exp;
    logic [3:0]  out_sig;

    int n_checks = 0;
    int n_fail   = 0;

    fpcvt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig)
    );

    always #5 clk = ~clk;

    // Reference: pick the smallest exponent bringing the magnitude under 2^SIG_W,
    // round half-up on the bit just below, renormalise or saturate.
    function automatic void ref_model(input int v, output int s, output int e,
                                      output int sg, output int lat);
        int m;
        s = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        if (m > MAXM) m = MAXM;
        e = 0;
        while (((m >> e) >= SIGL) && (e < EMAX)) e++;
        lat = e + 1;
        if ((m >> e) >= SIGL) begin
            e  = EMAX;
            sg = SIGL - 1;
            return;
        end
        sg = (m >> e) + ((e > 0) ? ((m >> (e - 1)) & 1) : 0);
        if (sg == SIGL) begin
            if (e < EMAX) begin
                e++;
                sg = SIGL / 2;
            end else begin
                sg = SIGL - 1;
            end
        end
    endfunction

    // Present a word (called #1 after an edge), wait for out_valid and report
    // what was seen; latency counts edges after the accepting edge.
    task automatic send_word(input logic [11:0] w, output int lat, output bit rdy_low_ok,
                             output bit accepted);
        accepted   = in_ready;
        in_data    = w;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = 12'($urandom);
        lat        = 0;
        rdy_low_ok = 1'b1;
        while (!out_valid && lat < TMO) begin
            if (in_ready) rdy_low_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_low_ok = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        n_checks++;
        if (out_sign !== 1'b0 || out_exp !== 3'd0 || out_sig !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_out: sign=%b exp=%0d sig=%0d, want 0 0 0", out_sign, out_exp, out_sig);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int dv [9] = '{422, -422, 0, 31, 62, 60, 23, 2047, -2048};
        int ds [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        int de [9] = '{5, 5, 0, 2, 3, 2, 1, 7, 7};
        int dsg[9] = '{13, 13, 0, 8, 8, 15, 12, 15, 15};
        int dl [9] = '{6, 6, 1, 2, 3, 3, 2, 8, 8};
        int lat; bit rok; bit acc;
        for (int i = 0; i < 9; i++) begin
            send_word(12'(dv[i]), lat, rok, acc);
            n_checks++;
            if (out_sign !== 1'(ds[i]) || out_exp !== 3'(de[i]) || out_sig !== 4'(dsg[i])) begin
                n_fail++;
                $display("FAIL dir_value(%0d): sign=%b exp=%0d sig=%0d, want %0d %0d %0d",
                         dv[i], out_sign, out_exp, out_sig, ds[i], de[i], dsg[i]);
            end
            n_checks++;
            if (lat != dl[i] || !rok || !acc) begin
                n_fail++;
                $display("FAIL dir_timing(%0d): latency=%0d ready_low=%b accepted=%b, want %0d 1 1",
                         dv[i], lat, rok, acc, dl[i]);
            end
            consume();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir_consume(%0d): out_valid=%b in_ready=%b, want 0 1",
                         dv[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        int s, e, sg, el, lat; bit rok; bit acc; bit early;
        logic [11:0] w;
        for (int i = 0; i < 40; i++) begin
            w     = 12'($urandom_range(0, 4095));
            early = 1'($urandom_range(0, 1));
            ref_model(int'($signed(w)), s, e, sg, el);
            out_ready = early;
            send_word(w, lat, rok, acc);
            n_checks++;
            if (out_sign !== 1'(s) || out_exp !== 3'(e) || out_sig !== 4'(sg) || lat != el) begin
                n_fail++;
                $display("FAIL rand(%0d): sign=%b exp=%0d sig=%0d lat=%0d, want %0d %0d %0d %0d",
                         $signed(w), out_sign, out_exp, out_sig, lat, s, e, sg, el);
            end
            if (early) begin
                @(posedge clk); #1;
                out_ready = 1'b0;
            end else begin
                consume();
            end
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_consume(early=%b): out_valid=%b in_ready=%b, want 0 1",
                         early, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; bit rok; bit acc; bit stable;
        logic s0; logic [2:0] e0; logic [3:0] g0;
        out_ready = 1'b0;
        send_word(12'd422, lat, rok, acc);
        s0 = out_sign; e0 = out_exp; g0 = out_sig;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== s0 ||
                out_exp !== e0 || out_sig !== g0) stable = 1'b0;
        end
        n_checks++;
        if (!stable || s0 !== 1'b0 || e0 !== 3'd5 || g0 !== 4'd13) begin
            n_fail++;
            $display("FAIL bp_hold: stable=%b sign=%b exp=%0d sig=%0d, want 1 0 5 13",
                     stable, s0, e0, g0);
        end
        consume();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        send_word(12'd60, lat, rok, acc);
        n_checks++;
        if (!acc || lat != 3 || out_exp !== 3'd2 || out_sig !== 4'd15) begin
            n_fail++;
            $display("FAIL bp_next: accepted=%b lat=%0d exp=%0d sig=%0d, want 1 3 2 15",
                     acc, lat, out_exp, out_sig);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat; bit rok; bit acc;
        out_ready = 1'b1;
        send_word(12'd23, lat, rok, acc);
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_one_cycle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        send_word(-12'sd422, lat, rok, acc);
        n_checks++;
        if (!acc || lat != 6 || out_sign !== 1'b1 || out_exp !== 3'd5 || out_sig !== 4'd13) begin
            n_fail++;
            $display("FAIL b2b_second: acc=%b lat=%0d sign=%b exp=%0d sig=%0d, want 1 6 1 5 13",
                     acc, lat, out_sign, out_exp, out_sig);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit stale;
        in_data  = 12'd2047;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_exp !== 3'd0 || out_sig !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b exp=%0d sig=%0d, want 0 1 0 0",
                     out_valid, in_ready, out_exp, out_sig);
        end
        @(negedge clk); rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL rst_stale: stale result seen=%b, want 0", stale);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
